// File: rtl/testbench_module.sv
// Five independent small datapath functions (priority encoder, comparator,
// 8:1 mux, weighted vote, 4x4 multiplier) behind one output register stage.
module testbench_module (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_integer,
  output logic [3:0]  most_significant_bit,
  output logic        multiple_ones,
  input  logic [3:0]  first_int,
  input  logic [3:0]  second_int,
  output logic        less,
  output logic        more,
  output logic        equal,
  output logic        one_bit_diff,
  input  logic [7:0]  input_values,
  input  logic [2:0]  selector,
  output logic        out_value,
  input  logic [5:0]  weights,
  input  logic [5:0]  doubles,
  output logic        weight_result,
  input  logic [3:0]  input1,
  input  logic [3:0]  input2,
  output logic [7:0]  combination_result
);

  logic [3:0] most_significant_bit_d, most_significant_bit_q;
  logic       multiple_ones_d, multiple_ones_q;
  logic       less_d, less_q;
  logic       more_d, more_q;
  logic       equal_d, equal_q;
  logic       one_bit_diff_d, one_bit_diff_q;
  logic       out_value_d, out_value_q;
  logic       weight_result_d, weight_result_q;
  logic [7:0] combination_result_d, combination_result_q;

  logic [4:0] ones_count;
  logic [3:0] diff_bits;
  logic [2:0] diff_count;
  logic [3:0] vote_total;
  logic [3:0] vote_yes;

  always_comb begin
    most_significant_bit_d = 4'd0;
    ones_count             = 5'd0;
    // Ascending scan: the last set bit seen is the highest one.
    for (int i = 0; i < 16; i++) begin
      if (input_integer[i]) begin
        most_significant_bit_d = 4'(i);
        ones_count             = ones_count + 5'd1;
      end
    end
    multiple_ones_d = (ones_count >= 5'd2);
  end

  always_comb begin
    less_d     = (first_int < second_int);
    more_d     = (first_int > second_int);
    equal_d    = (first_int == second_int);
    diff_bits  = first_int ^ second_int;
    diff_count = 3'd0;
    for (int i = 0; i < 4; i++) begin
      diff_count = diff_count + {2'd0, diff_bits[i]};
    end
    one_bit_diff_d = (diff_count == 3'd1);
  end

  assign out_value_d = input_values[selector];

  // Every voter carries weight 1, plus 1 more when doubled, regardless of vote.
  always_comb begin
    vote_total = 4'd6;
    vote_yes   = 4'd0;
    for (int i = 0; i < 6; i++) begin
      vote_total = vote_total + {3'd0, doubles[i]};
      if (weights[i]) begin
        vote_yes = vote_yes + 4'd1 + {3'd0, doubles[i]};
      end
    end
    weight_result_d = ({vote_yes, 1'b0} > {1'b0, vote_total});
  end

  assign combination_result_d = {4'd0, input1} * {4'd0, input2};

  always_ff @(posedge clk) begin
    if (rst) begin
      most_significant_bit_q <= 4'd0;
      multiple_ones_q        <= 1'b0;
      less_q                 <= 1'b0;
      more_q                 <= 1'b0;
      equal_q                <= 1'b0;
      one_bit_diff_q         <= 1'b0;
      out_value_q            <= 1'b0;
      weight_result_q        <= 1'b0;
      combination_result_q   <= 8'd0;
    end else begin
      most_significant_bit_q <= most_significant_bit_d;
      multiple_ones_q        <= multiple_ones_d;
      less_q                 <= less_d;
      more_q                 <= more_d;
      equal_q                <= equal_d;
      one_bit_diff_q         <= one_bit_diff_d;
      out_value_q            <= out_value_d;
      weight_result_q        <= weight_result_d;
      combination_result_q   <= combination_result_d;
    end
  end

  assign most_significant_bit = most_significant_bit_q;
  assign multiple_ones        = multiple_ones_q;
  assign less                 = less_q;
  assign more                 = more_q;
  assign equal                = equal_q;
  assign one_bit_diff         = one_bit_diff_q;
  assign out_value            = out_value_q;
  assign weight_result        = weight_result_q;
  assign combination_result   = combination_result_q;

endmodule

// File: tb/tb_testbench_module.sv
// Directed self-checking bench for testbench_module; expected values are
// hand-computed constants in the tables below.
module tb_testbench_module;

  logic        clk;
  logic        rst;
  logic [15:0] input_integer;
  logic [3:0]  most_significant_bit;
  logic        multiple_ones;
  logic [3:0]  first_int;
  logic [3:0]  second_int;
  logic        less;
  logic        more;
  logic        equal;
  logic        one_bit_diff;
  logic [7:0]  input_values;
  logic [2:0]  selector;
  logic        out_value;
  logic [5:0]  weights;
  logic [5:0]  doubles;
  logic        weight_result;
  logic [3:0]  input1;
  logic [3:0]  input2;
  logic [7:0]  combination_result;

  int pass_count = 0;
  int fail_count = 0;
  int check_count = 0;

  testbench_module dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_integer        (input_integer),
    .most_significant_bit (most_significant_bit),
    .multiple_ones        (multiple_ones),
    .first_int            (first_int),
    .second_int           (second_int),
    .less                 (less),
    .more                 (more),
    .equal                (equal),
    .one_bit_diff         (one_bit_diff),
    .input_values         (input_values),
    .selector             (selector),
    .out_value            (out_value),
    .weights              (weights),
    .doubles              (doubles),
    .weight_result        (weight_result),
    .input1               (input1),
    .input2               (input2),
    .combination_result   (combination_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge before sampling.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  logic [15:0] pe_in   [8] = '{16'd0, 16'd3, 16'd15, 16'd2500, 16'd10000, 16'd21846, 16'hFFFF, 16'h0020};
  logic [3:0]  pe_msb  [8] = '{4'd0, 4'd1, 4'd3, 4'd11, 4'd13, 4'd14, 4'd15, 4'd5};
  logic        pe_mo   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic [3:0]  cmp_a   [7] = '{4'd2, 4'd5, 4'd4, 4'd15, 4'd0, 4'd7, 4'd8};
  logic [3:0]  cmp_b   [7] = '{4'd3, 4'd3, 4'd4, 4'd0, 4'd15, 4'd8, 4'd7};
  logic [3:0]  cmp_exp [7] = '{4'b1001, 4'b0100, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0100};

  logic [5:0]  vote_w  [4] = '{6'b100100, 6'b000000, 6'b111111, 6'b000111};
  logic [5:0]  vote_d  [4] = '{6'b000110, 6'b000110, 6'b000110, 6'b000000};
  logic        vote_exp[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic [3:0]  mul_a   [6] = '{4'd11, 4'd11, 4'd10, 4'd12, 4'd15, 4'd0};
  logic [3:0]  mul_b   [6] = '{4'd7, 4'd6, 4'd6, 4'd7, 4'd15, 4'd9};
  logic [7:0]  mul_exp [6] = '{8'd77, 8'd66, 8'd60, 8'd84, 8'd225, 8'd0};

  initial begin
    rst           = 1'b1;
    input_integer = 16'hFFFF;
    first_int     = 4'd6;
    second_int    = 4'd6;
    input_values  = 8'hFF;
    selector      = 3'd3;
    weights       = 6'b111111;
    doubles       = 6'b111111;
    input1        = 4'd15;
    input2        = 4'd15;

    applyStimulus();
    applyStimulus();
    checkOutput("reset_msb", {4'd0, most_significant_bit}, 8'd0);
    checkOutput("reset_multi", {7'd0, multiple_ones}, 8'd0);
    checkOutput("reset_cmp", {4'd0, less, more, equal, one_bit_diff}, 8'd0);
    checkOutput("reset_mux", {7'd0, out_value}, 8'd0);
    checkOutput("reset_vote", {7'd0, weight_result}, 8'd0);
    checkOutput("reset_mul", combination_result, 8'd0);

    rst = 1'b0;
    applyStimulus();
    checkOutput("post_reset_msb", {4'd0, most_significant_bit}, 8'd15);
    checkOutput("post_reset_equal", {7'd0, equal}, 8'd1);
    checkOutput("post_reset_mul", combination_result, 8'd225);
    checkOutput("post_reset_vote", {7'd0, weight_result}, 8'd1);

    for (int i = 0; i < 8; i++) begin
      input_integer = pe_in[i];
      applyStimulus();
      checkOutput($sformatf("pe_msb_%0d", pe_in[i]), {4'd0, most_significant_bit}, {4'd0, pe_msb[i]});
      checkOutput($sformatf("pe_multi_%0d", pe_in[i]), {7'd0, multiple_ones}, {7'd0, pe_mo[i]});
    end

    for (int i = 0; i < 7; i++) begin
      first_int  = cmp_a[i];
      second_int = cmp_b[i];
      applyStimulus();
      checkOutput($sformatf("cmp_%0d_%0d", cmp_a[i], cmp_b[i]),
                  {4'd0, less, more, equal, one_bit_diff}, {4'd0, cmp_exp[i]});
    end

    input_values = 8'b10101010;
    for (int s = 0; s < 8; s++) begin
      selector = 3'(s);
      applyStimulus();
      checkOutput($sformatf("mux_sel_%0d", s), {7'd0, out_value}, {7'd0, 1'(s % 2)});
    end

    for (int i = 0; i < 4; i++) begin
      weights = vote_w[i];
      doubles = vote_d[i];
      applyStimulus();
      checkOutput($sformatf("vote_%0d", i), {7'd0, weight_result}, {7'd0, vote_exp[i]});
    end

    for (int i = 0; i < 6; i++) begin
      input1 = mul_a[i];
      input2 = mul_b[i];
      applyStimulus();
      checkOutput($sformatf("mul_%0dx%0d", mul_a[i], mul_b[i]), combination_result, mul_exp[i]);
    end

    // Other groups must still hold their last results after the multiplier steps.
    checkOutput("hold_msb", {4'd0, most_significant_bit}, 8'd5);
    checkOutput("hold_cmp", {4'd0, less, more, equal, one_bit_diff}, 8'b0100);
    checkOutput("hold_mux", {7'd0, out_value}, 8'd1);

    // A mid-cycle input change must not show until the next edge.
    input1 = 4'd3;
    input2 = 4'd5;
    #3;
    checkOutput("midcycle_mul", combination_result, 8'd0);
    applyStimulus();
    checkOutput("next_edge_mul", combination_result, 8'd15);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/testbench_module.md
Name: testbench_module

Overview:
- Bundle of five independent small datapath functions behind one clocked output register stage:
  - 16-bit priority encoder with a multi-one flag
  - 4-bit magnitude comparator with a Hamming-distance-1 flag
  - 8:1 bit multiplexer
  - 6-voter weighted majority
  - 4x4 unsigned multiplier
- Used as a standalone combinational-logic exercise block. All results appear one clock after their inputs are sampled.

Parameters:
- None. All widths are fixed as listed under Ports.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- input_integer  input  16  unsigned value for the priority encoder
- most_significant_bit  output  4  index of the highest set bit of input_integer
- multiple_ones  output  1  1 when input_integer has two or more bits set
- first_int  input  4  comparator operand A (unsigned)
- second_int  input  4  comparator operand B (unsigned)
- less  output  1  A < B
- more  output  1  A > B
- equal  output  1  A == B
- one_bit_diff  output  1  A and B differ in exactly one bit position
- input_values  input  8  mux data inputs
- selector  input  3  mux select
- out_value  output  1  input_values[selector]
- weights  input  6  vote bits; 1 = yes vote for voter i
- doubles  input  6  1 = voter i's vote counts double
- weight_result  output  1  weighted strict-majority result
- input1  input  4  multiplicand (unsigned)
- input2  input  4  multiplier (unsigned)
- combination_result  output  8  input1 * input2

Behaviour:
- Clocking and reset
  - Every output is a flop updated on the rising clk edge from the current inputs.
  - Latency is exactly 1 cycle. There is no handshake or enable; the block samples every cycle.
  - When rst=1 at a rising edge, all outputs become 0, including equal.
  - Reset has priority over input sampling. The first valid results appear at the first edge after rst deasserts.
- Priority encoder
  - most_significant_bit = largest i such that input_integer[i]=1.
  - multiple_ones = (popcount(input_integer) >= 2).
  - For input_integer = 0: most_significant_bit = 0 and multiple_ones = 0.
  - Bit 0 alone also gives most_significant_bit = 0. The two cases are distinguishable by the input value only.
- Comparator
  - Unsigned compare. Exactly one of less/more/equal is 1 in every non-reset cycle.
  - one_bit_diff = (popcount(first_int XOR second_int) == 1).
  - Numeric adjacency alone does not set it: 7 vs 8 gives 0.
- Mux
  - out_value = input_values[selector]. All 8 selector codes are valid; there is no out-of-range case.
- Weighted vote
  - Voter weight w_i = 1 + doubles[i].
  - total = sum of w_i, range 6..12.
  - yes = sum of w_i over the voters with weights[i]=1.
  - weight_result = (2*yes > total). A tie gives 0.
  - doubles bits of voters that vote no still count toward total.
- Multiplier
  - combination_result = input1 * input2, unsigned, 8-bit, never overflows (max 15*15 = 225).
- Inputs
  - All functions are independent. Changing one input group never affects the other outputs.
  - Inputs changing mid-cycle have no effect until the next rising edge.

Test Plan:
- Reset
  - Hold rst=1 for 2 cycles with non-zero inputs -> all outputs 0.
  - Deassert rst -> the next edge shows valid results.
- Priority encoder, cycle through input_integer = 0, 3, 15, 2500, 10000, 21846, 0xFFFF, 0x0020 -> (msb, multiple_ones):
  - 0 -> (0,0); 3 -> (1,1); 15 -> (3,1); 2500 -> (11,1)
  - 10000 -> (13,1); 21846 -> (14,1); 0xFFFF -> (15,1); 0x0020 -> (5,0)
- Comparator, as (A,B) -> (less,more,equal,one_bit_diff):
  - (2,3) -> (1,0,0,1); (5,3) -> (0,1,0,0); (4,4) -> (0,0,1,0)
  - (15,0) -> (0,1,0,0); (0,15) -> (1,0,0,0); (7,8) -> (1,0,0,0); (8,7) -> (0,1,0,0)
- Mux: input_values = 0b10101010, selector stepped 0..7 -> out_value sequence 0,1,0,1,0,1,0,1, each 1 cycle after the select change.
- Vote, with doubles = 0b000110 in all three cases:
  - weights 0b100100 -> 0 (yes 3 of total 8)
  - weights 0b000000 -> 0
  - weights 0b111111 -> 1
  - Tie case: weights 0b000111 with doubles 0b000000 -> 0 (yes 3 of total 6).
- Multiplier:
  - 11*7 -> 77; 11*6 -> 66; 10*6 -> 60; 12*7 -> 84
  - Boundaries: 15*15 -> 225; 0*9 -> 0.
